// File: rtl/encryptor_iter.sv
// rtl/encryptor_iter.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion (optional CBC via ENC_CBC_EN)
module encryptor_iter #(
    parameter bit DONE_PULSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
`ifdef ENC_CBC_EN
    input  logic [127:0] iv,
    input  logic         chain,
`endif
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [127:0] rk_next;
    logic [127:0] round_out;
    logic [127:0] blk;
    logic [31:0]  kt, n0, n1, n2, n3;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];

    // Block entering round 0: plain ECB, or XORed with the chaining value in CBC builds
    always_comb begin
`ifdef ENC_CBC_EN
        blk = plaintext ^ (chain ? ciphertext : iv);
`else
        blk = plaintext;
`endif
    end

    // Next round key: RotWord/SubWord/rcon on word 3, then the XOR chain w0..w3
    always_comb begin
        kt = {sbox(rk_reg[23:16]), sbox(rk_reg[15:8]), sbox(rk_reg[7:0]), sbox(rk_reg[31:24])}
             ^ {rcon, 24'h000000};
        n0 = rk_reg[127:96] ^ kt;
        n1 = rk_reg[95:64]  ^ n0;
        n2 = rk_reg[63:32]  ^ n1;
        n3 = rk_reg[31:0]   ^ n2;
        rk_next = {n0, n1, n2, n3};
    end

    // Round function: SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_reg[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            round_out[127-8*i -: 8] = ((rnd == 4'd10) ? sr[i] : mc[i]) ^ rk_next[127-8*i -: 8];
        end
    end

    // Control FSM and all datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm        <= IDLE;
            rnd        <= 4'd0;
            rcon       <= 8'h00;
            state_reg  <= '0;
            rk_reg     <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (fsm)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= blk ^ key;
                        rk_reg    <= key;
                        rcon      <= 8'h01;
                        rnd       <= 4'd1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fsm       <= RUN;
                    end else if (DONE_PULSE && fsm == DONE) begin
                        done <= 1'b0;
                        fsm  <= IDLE;
                    end
                end
                RUN: begin
                    state_reg <= round_out;
                    rk_reg    <= rk_next;
                    rcon      <= xtime(rcon);
                    if (rnd == 4'd10) begin
                        rnd        <= 4'd0;
                        ciphertext <= round_out;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        fsm        <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    rnd_range: assert property (@(posedge clk) disable iff (!rst) rnd <= 4'd10);

endmodule

// File: doc/encryptor_iter.md
Name: encryptor_iter

Overview:
- Iterative AES-128 encryptor (FIPS-197). It is the forward-direction counterpart of the team's decryptor: it takes a 128-bit plaintext and a 128-bit key and produces a 128-bit ciphertext.
- One round per clock. The key schedule is expanded on the fly, one round key per cycle, so no stored schedule is needed.
- Sits alongside the decryptor in the crypto datapath. Byte order matches the codebase's matrixify convention: byte 0 = bits [127:120], state filled column-major.

Parameters:
- DONE_PULSE, 0, 0 = done is a level held until the next accepted start; 1 = done is a one-cycle pulse and ciphertext still holds.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to encrypt; sampled only in IDLE or DONE.
- plaintext  input  128  block to encrypt; sampled on the accepted start edge.
- key  input  128  cipher key; sampled on the accepted start edge.
- ciphertext  output  128  result register; valid while done=1 (DONE_PULSE=0) or from the done pulse onward (DONE_PULSE=1).
- busy  output  1  high while rounds are in progress.
- done  output  1  completion flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; ciphertext = 0, done = 0, busy = 0.
  - Round counter, state register and round-key register all cleared.
- FSM states: IDLE, RUN, DONE.
- Start acceptance:
  - Accepted only in IDLE or DONE; ignored in RUN.
  - On the accepted edge (E0): state_reg <= plaintext ^ key (round 0 AddRoundKey), rk_reg <= key, rcon <= 0x01, rnd <= 1, busy <= 1, done <= 0, FSM -> RUN.
- RUN, edges E1..E10 (one per round):
  - rk_next = expand(rk_reg, rcon). Expansion: RotWord, SubWord and rcon applied to word 3, then the XOR chain across w0..w3.
  - state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk_next. MixColumns is skipped when rnd==10.
  - rk_reg <= rk_next; rcon <= xtime(rcon), giving 0x1b after 0x80.
  - rnd increments.
- Completion, at E10:
  - ciphertext <= round-10 result; busy <= 0; done <= 1; FSM -> DONE.
  - Latency: done observed 10 cycles after the start edge.
- DONE:
  - ciphertext holds until the next completion.
  - DONE_PULSE=0: done stays high until the next start is accepted.
  - DONE_PULSE=1: done drops after one cycle and the FSM returns to IDLE.
- Start in the same cycle that done is high: accepted. done goes low next cycle and a new run begins, giving back-to-back throughput of 1 block per 11 cycles.
- Input changes during RUN: ignored, because operands are captured at E0.
- Reset mid-RUN: immediate abort to IDLE. ciphertext is cleared and there is no partial output.
- rnd is a 4-bit counter and never exceeds 10. Reaching values 11–15 is a design error and must be covered by an assertion.
- S-box is a combinational 256-entry lookup shared by the datapath and the key path: 16 instances for the state, 4 for the key.

Optional Feature:
- Macro: ENC_CBC_EN.
- With ENC_CBC_EN defined:
  - Adds input iv [127:0] and input chain [1].
  - On an accepted start, the block fed to round 0 is plaintext ^ (chain ? ciphertext : iv). ciphertext here is the previous result register.
  - With chain=1 after reset, the chaining value is ciphertext=0.
  - Latency is unchanged.
- Without ENC_CBC_EN: neither port exists and the block is pure ECB (plaintext used directly).

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, done exactly 10 cycles after start, busy high for cycles 1–10.
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Assert start again on the done cycle with pt/key all zero -> 66e94bd4ef8a2c3b884cfa59ca342b2e 11 cycles after the first done.
- Start pulsed at cycles 3 and 7 of a RUN, with changed pt/key -> ignored, result equals the C.1 vector, no extra done.
- rst driven low at round 5, asynchronously, mid-cycle -> done=0, busy=0, ciphertext=0 immediately. A new start after release gives the correct C.1 result.
- DONE_PULSE=1: C.1 vector -> done high for exactly one cycle, ciphertext holds 69c4e0d8... afterwards.
- ENC_CBC_EN: key 2b7e1516..., iv 000102030405060708090a0b0c0d0e0f, chain=0, pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d. Then chain=1, pt ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
